// File: rtl/data_mem_if.sv
// Bus between the datapath and the data memory: address from the ALU,
// write data from rs2, MemWrite enable, and combinational load data back.
interface data_mem_if;
    logic        WE;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;

    modport master (
        output WE,
        output A,
        output WD,
        input  RD
    );

    modport slave (
        input  WE,
        input  A,
        input  WD,
        output RD
    );
endinterface

// File: rtl/data_mem.sv
// Word-organised data memory: synchronous word writes, combinational reads,
// asynchronous active-low reset that clears every word.
// A[1:0] and the address bits above the index are ignored, so addresses
// alias modulo 4*DEPTH bytes.
module data_mem #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input logic       clk,
    input logic       rst_n,
    data_mem_if.slave bus
);
    logic [31:0]      r_mem [DEPTH];
    logic [IDX_W-1:0] w_idx;
    logic             w_unused_addr;

    assign w_idx = bus.A[IDX_W+1:2];

    // Byte-offset and aliasing bits carry no meaning for a word memory.
    assign w_unused_addr = &{1'b0, bus.A[31:IDX_W+2], bus.A[1:0]};

    // Storage: reset clears all words at once; otherwise write the indexed word when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.WE) begin
            r_mem[w_idx] <= bus.WD;
        end
    end

    // Load data follows the address with no clock and no write-through bypass.
    always_comb begin
        bus.RD = r_mem[w_idx];
    end
endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: stimulus pushes expected read data from a
// sparse word-addressed reference model; a monitor pops and compares RD.
module tb_data_mem;
    localparam int unsigned DEPTH = 1024;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic rst_n;
    data_mem_if bus ();

    data_mem #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t        sb_q[$];
    logic [31:0] ref_mem [int unsigned];
    int          checks   = 0;
    int          failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: memory is a byte-address space folded to words modulo 4*DEPTH.
    function automatic int unsigned word_of(logic [31:0] a);
        return (int'(a) >>> 0) / 4 % DEPTH;
    endfunction

    function automatic logic [31:0] model_rd(logic [31:0] a);
        int unsigned w;
        w = (a / 4) % DEPTH;
        if (!rst_n) return 32'h0;
        if (ref_mem.exists(w)) return ref_mem[w];
        return 32'h0;
    endfunction

    task automatic expect_rd(input string name);
        exp_t e;
        e.name = name;
        e.addr = bus.A;
        e.exp  = model_rd(bus.A);
        sb_q.push_back(e);
        #1;
    endtask

    task automatic read_at(input logic [31:0] a, input string name);
        bus.A = a;
        #1;
        expect_rd(name);
    endtask

    // One clock with the given bus values; checks RD just before and after the edge.
    task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic we, input string name);
        @(negedge clk);
        bus.A  = a;
        bus.WD = d;
        bus.WE = we;
        #1;
        expect_rd({name, "_pre"});
        @(posedge clk);
        if (we && rst_n) ref_mem[(a / 4) % DEPTH] = d;
        #1;
        expect_rd({name, "_post"});
        bus.WE = 1'b0;
    endtask

    // Monitor: compare RD against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            wait (sb_q.size() != 0);
            e = sb_q.pop_front();
            checks++;
            if (bus.RD !== e.exp) begin
                failures++;
                $display("FAIL %s A=%h RD=%h expected=%h", e.name, e.addr, bus.RD, e.exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        we;

        rst_n  = 1'b0;
        bus.WE = 1'b0;
        bus.A  = '0;
        bus.WD = '0;
        #3;
        read_at(32'h0000_0000, "reset_a0");
        read_at(32'h0000_3FFC, "reset_a3ffc");
        @(negedge clk);
        rst_n = 1'b1;

        // Write and read back, sub-word offset ignored.
        cycle(32'd10, 32'hDEAD_BEEF, 1'b1, "wr10");
        cycle(32'd10, 32'h0, 1'b0, "hold10");
        read_at(32'd8, "rd8_same_word");

        cycle(32'd20, 32'hCAFE_BABE, 1'b1, "wr20");
        cycle(32'd20, 32'h0, 1'b0, "hold20");
        read_at(32'd10, "rd10");
        read_at(32'd30, "rd30_unwritten");

        // WE=0 gating over several edges.
        for (int i = 0; i < 4; i++) cycle(32'd10, 32'h1234_5678, 1'b0, "we0_gate");

        // Aliasing modulo 4*DEPTH bytes.
        read_at(32'h0000_1008, "alias_rd");
        cycle(32'h0000_1008, 32'h55AA_55AA, 1'b1, "alias_wr");
        read_at(32'd8, "alias_rd8");
        read_at(32'hFFFF_F008, "alias_high");

        // Asynchronous reset between edges with WE=1.
        @(negedge clk);
        bus.A  = 32'd10;
        bus.WD = 32'hFFFF_FFFF;
        bus.WE = 1'b1;
        #1;
        rst_n = 1'b0;
        ref_mem.delete();
        #1;
        expect_rd("async_rst_a10");
        read_at(32'd20, "async_rst_a20");
        bus.A = 32'd10;
        @(posedge clk);
        #1;
        expect_rd("rst_blocks_write");
        @(negedge clk);
        bus.WE = 1'b0;
        rst_n  = 1'b1;
        #1;
        expect_rd("after_release");
        cycle(32'd10, 32'h0BAD_F00D, 1'b1, "post_rst_wr");
        read_at(32'd20, "post_rst_a20");

        // Random traffic over a small window so addresses collide and alias.
        for (int i = 0; i < 300; i++) begin
            a  = {$urandom_range(0, 3) == 0 ? 32'($urandom) & 32'hFFFF_C000 : 32'h0}
                 | ({$urandom_range(0, 31), 2'b00} + 32'($urandom_range(0, 3)));
            d  = $urandom;
            we = ($urandom_range(0, 2) != 0);
            cycle(a, d, we, "rand_cyc");
            read_at({$urandom_range(0, 31), 2'b00} | 32'($urandom_range(0, 3)), "rand_rd");
        end

        // Full-range boundary words.
        cycle(32'h0000_0FFC, 32'hA5A5_0001, 1'b1, "top_word");
        read_at(32'hFFFF_FFFF, "top_alias");
        cycle(32'h0000_0000, 32'h5A5A_0002, 1'b1, "bottom_word");
        read_at(32'h0000_1003, "bottom_alias");

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) #1;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
